// File: rtl/memref_arb_pkg.sv
// Shared constants and types for the memory-reference arbiter and its
// round-robin picker.
package memref_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int ID_W        = $clog2(DEF_NUM_REQ);

  typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/memref_rr_picker.sv
// Combinational round-robin picker: the first active requester at or after
// ptr (wrapping) wins and is reported one-hot and as an index.
module memref_rr_picker
  import memref_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         active,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int         IW  = $clog2(NUM_REQ);
  localparam logic [IW:0] N_W = (IW+1)'(NUM_REQ);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          hit;

  // Walk the ring from ptr; sum carries one extra bit so the wrap also works
  // for non-power-of-two requester counts.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    hit   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum  = {1'b0, ptr} + (IW+1)'(k);
      sum  = (sum >= N_W) ? (sum - N_W) : sum;
      cand = sum[IW-1:0];
      hit  = !any && active[cand];
      idx  = hit ? cand : idx;
      any  = any | hit;
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/memref_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency memory among NUM_REQ
// requesters, with a 1-deep read tag pipe and a sticky protocol-error flag.
module memref_arbiter
  import memref_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = 32,
  parameter int SIZE    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_rd_en,
  input  logic [NUM_REQ-1:0]                    req_wr_en,
  input  logic [NUM_REQ-1:0][$clog2(SIZE)-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]         req_din,
  output logic [NUM_REQ-1:0]                    grant,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [WIDTH-1:0]                      rsp_dout,
  output logic                                  mem_rd_en,
  output logic                                  mem_wr_en,
  output logic [$clog2(SIZE)-1:0]               mem_addr,
  output logic [WIDTH-1:0]                      mem_din,
  input  logic                                  mem_dout_valid,
  input  logic [WIDTH-1:0]                      mem_dout,
  output logic                                  err
);

  localparam int            IW      = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] active;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               gnt_rd;
  logic               gnt_wr;

  logic [IW-1:0] ptr_q, ptr_d;
  logic          pend_q, pend_d;
  logic [IW-1:0] tag_q, tag_d;
  logic          err_q, err_d;

  // Masking requests during reset keeps every grant-derived output quiet.
  assign active = rst ? '0 : (req_rd_en | req_wr_en);

  memref_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .active (active),
    .ptr    (ptr_q),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Memory-side muxing, response steering and next-state for ptr/tag/err.
  always_comb begin
    gnt_rd    = pick_any & req_rd_en[pick_idx];
    gnt_wr    = pick_any & req_wr_en[pick_idx];
    grant     = pick_grant;
    mem_wr_en = gnt_wr;
    mem_rd_en = gnt_rd & ~gnt_wr;
    mem_addr  = pick_any ? req_addr[pick_idx] : '0;
    mem_din   = pick_any ? req_din[pick_idx]  : '0;

    rsp_dout         = mem_dout;
    rsp_valid        = '0;
    rsp_valid[tag_q] = pend_q & mem_dout_valid & ~rst;

    ptr_d  = pick_any ? ((pick_idx == LAST_ID) ? '0 : (pick_idx + IW'(1))) : ptr_q;
    pend_d = mem_rd_en;
    tag_d  = mem_rd_en ? pick_idx : tag_q;
    // Conflicting enables, unsolicited data and a missing response all latch.
    err_d  = err_q
           | (gnt_rd & gnt_wr)
           | (mem_dout_valid & ~pend_q)
           | (pend_q & ~mem_dout_valid);
  end

  // State registers; reset drops any in-flight read tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      pend_q <= 1'b0;
      tag_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      pend_q <= pend_d;
      tag_q  <= tag_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: doc/memref_arbiter.md
MEMREF_ARBITER -- requirements
Module: memref_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  - NUM_REQ, 4, number of requesters (2..8)
  - WIDTH, 32, data width
  - SIZE, 8, memory depth (AW = $clog2(SIZE))
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  - clk  input  1  single clock; all logic on posedge
  - rst  input  1  asynchronous, active-high reset
  - req_rd_en  input  NUM_REQ  per-requester read request
  - req_wr_en  input  NUM_REQ  per-requester write request
  - req_addr  input  NUM_REQ x AW  per-requester address
  - req_din  input  NUM_REQ x WIDTH  per-requester write data
  - grant  output  NUM_REQ  one-hot grant, same cycle as request
  - rsp_valid  output  NUM_REQ  one-hot read-data valid to the owning requester
  - rsp_dout  output  WIDTH  read data, broadcast to all requesters
  - mem_rd_en  output  1  read enable to the 1-cycle-latency memory read port
  - mem_wr_en  output  1  write enable to the memory write port
  - mem_addr  output  AW  shared address
  - mem_din  output  WIDTH  write data
  - mem_dout_valid  input  1  memory read-data valid
  - mem_dout  input  WIDTH  memory read data
  - err  output  1  sticky protocol-error flag

Function
REQ-003 A requester SHALL be active when its req_rd_en or req_wr_en is 1.
REQ-004 grant SHALL be combinational: at most one bit set, chosen round-robin among active requesters, starting the search at pointer ptr.
REQ-005 After any cycle with a grant to index i, ptr SHALL become (i+1) mod NUM_REQ. With no grant, ptr SHALL hold.
REQ-006 The granted requester's addr and din SHALL drive mem_addr and mem_din combinationally. mem_rd_en and mem_wr_en SHALL copy its enables.
REQ-007 With no grant, mem_rd_en and mem_wr_en SHALL be 0, and mem_addr and mem_din SHALL be 0.
REQ-008 If the granted requester asserts both rd and wr, the write SHALL proceed, mem_rd_en SHALL be 0, and err SHALL be set.
REQ-009 Ungranted requesters SHALL hold their request. The block SHALL NOT buffer requests.
REQ-010 On each granted read, the block SHALL register the requester id and a pending bit (a 1-deep tag pipe).
REQ-011 In the next cycle, rsp_valid[id] SHALL equal mem_dout_valid AND pending. rsp_dout SHALL pass mem_dout through combinationally.
REQ-012 A new read grant in the same cycle as a returning response SHALL be allowed, giving full throughput of 1 read per cycle.
REQ-013 mem_dout_valid=1 while pending=0 SHALL set err. rsp_valid SHALL stay all 0 in that case.
REQ-014 pending=1 with mem_dout_valid=0 SHALL set err. The response SHALL be dropped and not retried.
REQ-015 err SHALL be sticky until rst.
REQ-016 Worst-case wait for a continuously active requester SHALL be NUM_REQ-1 cycles.

Reset
REQ-017 On rst=1 the block SHALL clear asynchronously: ptr=0, pending=0, tag id=0, err=0.
REQ-018 While rst=1, grant, rsp_valid, mem_rd_en and mem_wr_en SHALL be 0 regardless of requests.
REQ-019 A read granted in the cycle before rst is asserted SHALL have its response discarded. No rsp_valid SHALL appear after reset release.
REQ-020 The first grant after rst deassertion SHALL favour requester 0.

Structure
REQ-021 A shared package memref_arb_pkg SHALL hold the default NUM_REQ, the id-width constant ($clog2(NUM_REQ)), and a requester-id typedef.
REQ-022 Round-robin selection (active vector plus ptr giving a one-hot grant and the index) SHALL be a combinational sub-module, memref_rr_picker.
REQ-023 ptr, the tag pipe and err SHALL reside in memref_arbiter.

Verification (NUM_REQ=4, WIDTH=32, SIZE=8)
REQ-024 Reset priority:
  - Stimulus: after reset, requesters 0 and 2 read addr 3 and addr 5.
  - Response: grant=0001 in cycle n, then 0100 in n+1; rsp_valid=0001 with mem[3] in n+1, rsp_valid=0100 with mem[5] in n+2.
REQ-025 Back-to-back fairness:
  - Stimulus: all 4 requesters hold wr_en continuously, each writing its index to addr=index.
  - Response: grants rotate 0001, 0010, 0100, 1000; mem[0..3]=0,1,2,3.
REQ-026 Pointer hold:
  - Stimulus: requester 1 reads, then idles 3 cycles, then requesters 1 and 3 both request.
  - Response: ptr stays 2 while idle; grant=1000 first.
REQ-027 Both enables:
  - Stimulus: requester 0 asserts rd and wr together to addr 1 with din=0xA5.
  - Response: mem[1]=0xA5, mem_rd_en=0, err=1 and stays 1.
REQ-028 Spurious data:
  - Stimulus: force mem_dout_valid=1 with no pending read.
  - Response: err=1, rsp_valid=0000.
REQ-029 Reset mid-read:
  - Stimulus: assert rst the cycle after a granted read.
  - Response: rsp_valid stays 0000, ptr=0, err=0 after release.
